ifu_fetch: RTL

//   Instruction fetch stage of the core. Drives byte address/enable to the sync instruction SRAM.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_fifo.sv | 66 ++++++
 rtl/ifu_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types, widths and helpers for the instruction fetch unit.
// Optional perf counters in ifu_fetch are enabled with IFU_PERF_CNT_EN.
package ifu_pkg;

    localparam int unsigned IFU_AW = 16;
    localparam int unsigned IFU_IW = 32;
    localparam logic [IFU_AW-1:0] IFU_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [IFU_AW-1:0] pc;
        logic [IFU_IW-1:0] ins;
    } fetch_ent_t;

    function automatic logic [IFU_AW-1:0] pc_next(input logic [IFU_AW-1:0] pc);
        return pc + IFU_AW'(4);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small circular fetch queue; flush wins over push. When empty, the head output
// keeps showing the last entry that was presented.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  fetch_ent_t    din,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output fetch_ent_t    head
);

    fetch_ent_t    mem [DEPTH];
    fetch_ent_t    last_q;
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = empty ? last_q : mem[rd_q];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            if (!empty) begin
                last_q <= mem[rd_q];
            end
            if (flush) begin
                rd_q    <= '0;
                wr_q    <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_q <= ptr_inc(wr_q);
                if (pop)  rd_q <= ptr_inc(rd_q);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: it is only observed through the count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_q] <= din;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: drives the sync instruction SRAM, queues returned words
// and hands {pc, ins} to exe. IFU_PERF_CNT_EN adds perf_fetch/perf_flush counters.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned   AW       = IFU_AW,
    parameter int unsigned   DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic          clk,
    input  logic          rstn,
    output logic [AW-1:0] ins_a,
    output logic          ins_e,
    input  logic [31:0]   ins,
    input  logic          br_vld,
    input  logic [AW-1:0] br_pc,
    output logic          ifu_vld,
    output logic [AW-1:0] ifu_pc,
    output logic [31:0]   ifu_ins,
    input  logic          ifu_rdy
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch,
    output logic [31:0]   perf_flush
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] resp_pc_q;
    logic          resp_vld_q;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          deq;
    logic          push;
    logic          credit;
    fetch_ent_t    din;
    fetch_ent_t    head;
    logic          unused_br_lsb;

    assign unused_br_lsb = ^br_pc[1:0];

    assign ifu_vld = !empty;
    assign ifu_pc  = head.pc;
    assign ifu_ins = head.ins;
    assign deq     = ifu_vld & ifu_rdy;
    // A response arriving in a redirect cycle belongs to the old path.
    assign push    = resp_vld_q & ~br_vld;
    assign din     = '{pc: resp_pc_q, ins: ins};
    // Queue slots plus the in-flight word must never exceed DEPTH.
    assign credit  = (32'(count) + 32'(resp_vld_q)) < DEPTH;

    always_comb begin
        ins_a = RESET_PC;
        ins_e = 1'b0;
        if (!rstn) begin
            ins_a = br_vld ? {br_pc[AW-1:2], 2'b00} : pc_q;
            ins_e = credit | deq | br_vld;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pc_q       <= RESET_PC;
            resp_vld_q <= 1'b0;
            resp_pc_q  <= RESET_PC;
        end else begin
            if (ins_e) begin
                pc_q <= pc_next(ins_a);
            end
            resp_vld_q <= ins_e;
            resp_pc_q  <= ins_a;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (din),
        .pop   (deq),
        .flush (br_vld),
        .count (count),
        .empty (empty),
        .full  (full),
        .head  (head)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rstn)
        !(push && full && !deq && !br_vld));

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            perf_fetch <= perf_fetch + 32'(deq);
            if (br_vld) begin
                perf_flush <= perf_flush + 32'(count) + 32'(resp_vld_q);
            end
        end
    end
`endif

endmodule
